// File: rtl/rename_stage.sv
// Rename stage: maps rd/rs1/rs2 through a RAT and allocates destinations from a circular free list.
// One cycle from accept to out_valid; in_ready drops when the output slot is held or the list is empty.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs1,
  output logic [PREG_W-1:0] out_prs2,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_regwrite,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg,
  output logic [PREG_W:0]   free_count,
  output logic              overflow_err
);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam logic [PREG_W:0]  FULL_CNT = (PREG_W+1)'(FL_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FL_DEPTH - 1);

  typedef struct packed {
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
    logic              regwrite;
  } slot_t;

  logic [PREG_W-1:0] rat       [ARCH_REGS];
  logic [PREG_W-1:0] free_list [FL_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PREG_W:0]   count;
  slot_t             slot;
  slot_t             slot_nxt;

  logic need_alloc;
  logic accept;
  logic pop;
  logic push_req;
  logic push;
  logic list_full;

  assign need_alloc = in_regwrite && (in_rd != 5'd0);
  assign list_full  = (count == FULL_CNT);
  // An empty list stalls even if retire pushes this cycle: no push-to-pop bypass.
  assign in_ready   = (!out_valid || out_ready) && !(in_valid && need_alloc && (count == '0));
  assign accept     = in_valid && in_ready;
  assign pop        = accept && need_alloc;
  assign push_req   = free_valid && (free_preg != '0);
  assign push       = push_req && (!list_full || pop);

  // Sources read the RAT as it stood before this cycle's rename.
  always_comb begin
    slot_nxt          = '0;
    slot_nxt.prs1     = rat[in_rs1];
    slot_nxt.prs2     = rat[in_rs2];
    slot_nxt.regwrite = pop;
    if (pop) begin
      slot_nxt.prd     = free_list[head];
      slot_nxt.old_prd = rat[in_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PREG_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) free_list[i] <= PREG_W'(ARCH_REGS + i);
      head         <= '0;
      tail         <= '0;
      count        <= FULL_CNT;
      overflow_err <= 1'b0;
      out_valid    <= 1'b0;
      slot         <= '0;
    end else begin
      if (pop) begin
        rat[in_rd] <= free_list[head];
        head       <= (head == LAST_PTR) ? '0 : head + 1'b1;
      end
      if (push) begin
        free_list[tail] <= free_preg;
        tail            <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      if (push_req && list_full && !pop) overflow_err <= 1'b1;
      case ({pop, push})
        2'b10:   count <= count - 1'b1;
        2'b01:   count <= count + 1'b1;
        default: count <= count;
      endcase
      if (accept) begin
        out_valid <= 1'b1;
        slot      <= slot_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_prs1     = slot.prs1;
  assign out_prs2     = slot.prs2;
  assign out_prd      = slot.prd;
  assign out_old_prd  = slot.old_prd;
  assign out_regwrite = slot.regwrite;
  assign free_count   = count;

endmodule

// File: tb/tb_rename_stage.sv
// Directed vector bench for rename_stage: table of {inputs, expected outputs} plus a free-list exhaustion sequence.
module tb_rename_stage;
  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic       in_regwrite;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_prs1;
  logic [5:0] out_prs2;
  logic [5:0] out_prd;
  logic [5:0] out_old_prd;
  logic       out_regwrite;
  logic       free_valid;
  logic [5:0] free_preg;
  logic [6:0] free_count;
  logic       overflow_err;

  rename_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
    .out_old_prd(out_old_prd), .out_regwrite(out_regwrite),
    .free_valid(free_valid), .free_preg(free_preg),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chk bit0: compare in_ready before the edge; bit1: compare out tags after the edge.
  typedef struct {
    int chk;
    int rst, iv, rd, rs1, rs2, rw, ordy, fv, fp;
    int e_rdy, e_ov, e_prs1, e_prs2, e_prd, e_old, e_rw, e_cnt, e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_err;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %0d, expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset       = v.rst[0];
    in_valid    = v.iv[0];
    in_rd       = v.rd[4:0];
    in_rs1      = v.rs1[4:0];
    in_rs2      = v.rs2[4:0];
    in_regwrite = v.rw[0];
    out_ready   = v.ordy[0];
    free_valid  = v.fv[0];
    free_preg   = v.fp[5:0];
    #1;
    if ((v.chk & 1) != 0) check("in_ready", idx, int'(in_ready), v.e_rdy);
    @(posedge clk);
    #1;
    check("out_valid", idx, int'(out_valid), v.e_ov);
    check("free_count", idx, int'(free_count), v.e_cnt);
    check("overflow_err", idx, int'(overflow_err), v.e_ovf);
    if ((v.chk & 2) != 0) begin
      check("out_prs1", idx, int'(out_prs1), v.e_prs1);
      check("out_prs2", idx, int'(out_prs2), v.e_prs2);
      check("out_prd", idx, int'(out_prd), v.e_prd);
      check("out_old_prd", idx, int'(out_old_prd), v.e_old);
      check("out_regwrite", idx, int'(out_regwrite), v.e_rw);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_chk = 0;
    n_err = 0;
    //            chk rst iv rd rs1 rs2 rw ordy fv fp   rdy ov prs1 prs2 prd old rw cnt ovf
    tbl.push_back('{2, 1, 0, 0, 0, 0, 0, 1, 0, 0,    0, 0, 0,  0,  0,  0,  0, 32, 0}); // reset
    tbl.push_back('{3, 0, 1, 5, 1, 2, 1, 1, 0, 0,    1, 1, 1,  2,  32, 5,  1, 31, 0}); // add x5,x1,x2
    tbl.push_back('{2, 1, 0, 0, 0, 0, 0, 1, 0, 0,    0, 0, 0,  0,  0,  0,  0, 32, 0});
    tbl.push_back('{3, 0, 1, 5, 5, 5, 1, 1, 0, 0,    1, 1, 5,  5,  32, 5,  1, 31, 0}); // add x5,x5,x5
    tbl.push_back('{3, 0, 1, 6, 5, 0, 1, 1, 0, 0,    1, 1, 32, 0,  33, 6,  1, 30, 0}); // sub x6,x5,x0
    tbl.push_back('{3, 0, 1, 0, 0, 0, 0, 1, 0, 0,    1, 1, 0,  0,  0,  0,  0, 30, 0}); // NOP
    tbl.push_back('{3, 0, 1, 0, 5, 6, 1, 1, 0, 0,    1, 1, 32, 33, 0,  0,  0, 30, 0}); // write to x0
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 0,    1, 0, 0,  0,  0,  0,  0, 30, 0}); // drain
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 1, 32,   1, 0, 0,  0,  0,  0,  0, 31, 0}); // retire p32
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 1, 33,   1, 0, 0,  0,  0,  0,  0, 32, 0}); // retire p33
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 1, 40,   1, 0, 0,  0,  0,  0,  0, 32, 1}); // push when full
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 1, 0,    1, 0, 0,  0,  0,  0,  0, 32, 1}); // p0 ignored
    tbl.push_back('{2, 1, 0, 0, 0, 0, 0, 1, 0, 0,    0, 0, 0,  0,  0,  0,  0, 32, 0}); // reset clears sticky
    tbl.push_back('{3, 0, 1, 0, 5, 6, 0, 1, 0, 0,    1, 1, 5,  6,  0,  0,  0, 32, 0}); // RAT identity
    tbl.push_back('{3, 0, 1, 5, 1, 2, 1, 1, 0, 0,    1, 1, 1,  2,  32, 5,  1, 31, 0}); // x5 -> p32
    tbl.push_back('{3, 0, 1, 7, 5, 0, 1, 1, 1, 50,   1, 1, 32, 0,  33, 7,  1, 31, 0}); // pop + push
    tbl.push_back('{3, 0, 1, 8, 7, 5, 1, 0, 0, 0,    0, 1, 32, 0,  33, 7,  1, 31, 0}); // held
    tbl.push_back('{3, 0, 1, 8, 7, 5, 1, 0, 0, 0,    0, 1, 32, 0,  33, 7,  1, 31, 0}); // held
    tbl.push_back('{3, 0, 1, 8, 7, 5, 1, 1, 0, 0,    1, 1, 33, 32, 34, 8,  1, 30, 0}); // release
    tbl.push_back('{2, 1, 1, 9, 0, 0, 1, 0, 0, 0,    0, 0, 0,  0,  0,  0,  0, 32, 0}); // reset mid-stream

    foreach (tbl[i]) apply(tbl[i], i);

    // Exhaust the free list: 32 allocations return p32..p63 in order.
    for (int i = 0; i < 32; i++) begin
      v = '{3, 0, 1, (i % 31) + 1, 0, 0, 1, 1, 0, 0,
            1, 1, 0, 0, 32 + i, (i < 31) ? (i + 1) : 32, 1, 31 - i, 0};
      apply(v, 100 + i);
    end
    // Empty list: the same-cycle retire of p7 must not bypass into the stalled rename.
    v = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 7,   0, 0, 0, 0, 0, 0, 0, 1, 0};
    apply(v, 200);
    v = '{3, 0, 1, 1, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 7, 63, 1, 0, 0};
    apply(v, 201);
    v = '{2, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 32, 0};
    apply(v, 202);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
